// File: rtl/uart_bus_pkg.sv
`default_nettype none
// ============================================================================
//  uart_bus_pkg
//  Command/response byte codes and parser states shared by uart_bus_master.
//  Revision: 1.0
// ============================================================================
package uart_bus_pkg;

    localparam logic [7:0] CMD_WR     = 8'h57;
    localparam logic [7:0] CMD_RD     = 8'h52;
    localparam logic [7:0] RSP_ACK    = 8'h4B;
    localparam logic [7:0] RSP_BADCMD = 8'h3F;
    localparam logic [7:0] RSP_ALIGN  = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_SEND = 3'd4
    } state_e;

    // Single-byte responses ride in the top byte of the tx shift register.
    function automatic logic [31:0] rsp_word(input logic [7:0] b);
        return {b, 24'h00_0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bus_master_if.sv
`default_nettype none
// ============================================================================
//  uart_bus_master_if
//  UART byte streams plus the peripheral bus driven by uart_bus_master.
//  Revision: 1.0
// ============================================================================
interface uart_bus_master_if;

    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        overrun;

    modport master (
        input  rx_valid, rx_byte, tx_ready, rdata,
        output tx_valid, tx_byte, rd, wr, addr, wdata, busy, overrun
    );

    modport slave (
        output rx_valid, rx_byte, tx_ready, rdata,
        input  tx_valid, tx_byte, rd, wr, addr, wdata, busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/uart_bus_txq.sv
`default_nettype none
// ============================================================================
//  uart_bus_txq
//  Loads a 1- or 4-byte response and hands it out MSB first over valid/ready.
//  Revision: 1.0
// ============================================================================
module uart_bus_txq (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        four_i,
    input  logic [31:0] data_i,
    input  logic        tx_ready_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_byte_o,
    output logic        done_o
);

    logic [31:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        xfer;

    assign xfer = valid_q & tx_ready_i;

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            sh_d    = data_i;
            cnt_d   = four_i ? 3'd4 : 3'd1;
            valid_d = 1'b1;
        end else if (xfer) begin
            sh_d    = {sh_q[23:0], 8'h00};
            cnt_d   = cnt_q - 3'd1;
            valid_d = (cnt_q != 3'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_byte_o  = sh_q[31:24];
    assign done_o     = xfer & (cnt_q == 3'd1);

endmodule
`default_nettype wire

// File: rtl/uart_bus_master.sv
`default_nettype none
// ============================================================================
//  uart_bus_master
//  Parses 'W'/'R' command bytes from the UART and issues single bus accesses.
//  Revision: 1.0
// ============================================================================
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000,
    parameter int TOW     = 20
) (
    input  logic               clk,
    input  logic               reset,
    uart_bus_master_if.master  bus
);

    localparam logic [2:0]     S_IDLE  = ST_IDLE;
    localparam logic [2:0]     S_ADDR  = ST_ADDR;
    localparam logic [2:0]     S_DATA  = ST_DATA;
    localparam logic [2:0]     S_BUS   = ST_BUS;
    localparam logic [2:0]     S_SEND  = ST_SEND;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

    logic [2:0]     state_q, state_d;
    logic           op_q, op_d;          // 1 = write
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [TOW-1:0] to_q, to_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           ovr_q, ovr_d;
    logic           busy_q;

    logic           ld, ld4, txq_done;
    logic [31:0]    ldata;
    logic           txq_valid;
    logic [7:0]     txq_byte;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        to_d    = '0;
        ovr_d   = ovr_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ld      = 1'b0;
        ld4     = 1'b0;
        ldata   = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (bus.rx_valid) begin
                    if (bus.rx_byte == CMD_WR) begin
                        op_d    = 1'b1;
                        state_d = S_ADDR;
                    end else if (bus.rx_byte == CMD_RD) begin
                        op_d    = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        ld      = 1'b1;
                        ldata   = rsp_word(RSP_BADCMD);
                        state_d = S_SEND;
                    end
                end
            end
            S_ADDR: begin
                // A byte arriving on the timeout cycle takes precedence.
                if (bus.rx_valid) begin
                    addr_d = {addr_q[23:0], bus.rx_byte};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (bus.rx_byte[1:0] != 2'b00) begin
                            ld      = 1'b1;
                            ldata   = rsp_word(RSP_ALIGN);
                            state_d = S_SEND;
                        end else if (op_q) begin
                            state_d = S_DATA;
                        end else begin
                            rd_d    = 1'b1;
                            state_d = S_BUS;
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TOW'(1);
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    wdata_d = {wdata_q[23:0], bus.rx_byte};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wr_d    = 1'b1;
                        state_d = S_BUS;
                    end
                end else if (to_q == TO_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TOW'(1);
                end
            end
            S_BUS: begin
                ld = 1'b1;
                if (op_q) begin
                    ldata = rsp_word(RSP_ACK);
                end else begin
                    ldata = bus.rdata;
                    ld4   = 1'b1;
                end
                state_d = S_SEND;
            end
            S_SEND: begin
                if (txq_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.rx_valid && (state_q == S_BUS || state_q == S_SEND)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            to_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            to_q    <= to_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    uart_bus_txq u_txq (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ld),
        .four_i     (ld4),
        .data_i     (ldata),
        .tx_ready_i (bus.tx_ready),
        .tx_valid_o (txq_valid),
        .tx_byte_o  (txq_byte),
        .done_o     (txq_done)
    );

    assign bus.tx_valid = txq_valid;
    assign bus.tx_byte  = txq_byte;
    assign bus.rd       = rd_q;
    assign bus.wr       = wr_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = ovr_q;

endmodule
`default_nettype wire
